// File: rtl/pc_fetch.sv
// PC / instruction-fetch stage: 3-phase sequencer, PC, instruction register and Sw8 debouncer.
// Optional PC overflow trap is built when PC_WRAP_TRAP_EN is defined.

package opcodes;

  typedef enum logic [1:0] {
    PcWait = 2'd0,
    PcInc  = 2'd1,
    PcJmp  = 2'd2
  } PcSel_t;

  typedef enum logic [3:0] {
    NOOP  = 4'h0,
    LDI   = 4'h1,
    LD    = 4'h2,
    ST    = 4'h3,
    ADD   = 4'h4,
    SUB   = 4'h5,
    ANDR  = 4'h6,
    ORR   = 4'h7,
    XORR  = 4'h8,
    SHL   = 4'h9,
    SHR   = 4'hA,
    JMP   = 4'hB,
    JZ    = 4'hC,
    WAIT0 = 4'hD,
    WAIT1 = 4'hE,
    HALT  = 4'hF
  } opcodes_t;

endpackage

module pc_fetch #(
  parameter int unsigned PC_WIDTH        = 8,
  parameter int unsigned INSTR_WIDTH     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  opcodes::PcSel_t        PcSel,
  input  logic [PC_WIDTH-1:0]    JmpAddr,
  input  logic [INSTR_WIDTH-1:0] ProgData,
  output logic [PC_WIDTH-1:0]    ProgAddr,
  output logic [INSTR_WIDTH-1:0] Instr,
  output opcodes::opcodes_t      OpCode,
  output logic                   IrValid,
  input  logic                   Sw8Raw,
  output logic                   Sw8,
  output logic                   Halted
);

  import opcodes::*;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_READ  = 2'd1,
    PH_EXEC  = 2'd2
  } phase_t;

  phase_t phase, phase_next;
  logic   ir_load;
  logic   pc_step;

  logic [PC_WIDTH-1:0] pc, pc_next;

  // ---------------------------------------------------------------------------
  // Phase sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) phase <= PH_FETCH;
    else         phase <= phase_next;
  end

  always_comb begin
    phase_next = PH_FETCH;
    unique case (phase)
      PH_FETCH: phase_next = PH_READ;
      PH_READ:  phase_next = PH_EXEC;
      PH_EXEC:  phase_next = PH_FETCH;
      default:  phase_next = PH_FETCH;
    endcase
  end

  always_comb begin
    ir_load = 1'b0;
    pc_step = 1'b0;
    unique case (phase)
      PH_READ: ir_load = 1'b1;
      PH_EXEC: pc_step = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program counter (optionally trapping on increment past the last address)
  // ---------------------------------------------------------------------------
`ifdef PC_WRAP_TRAP_EN
  logic halted, halted_next;

  always_comb begin
    pc_next     = pc;
    halted_next = halted;
    if (pc_step && !halted) begin
      case (PcSel)
        PcInc: begin
          if (pc == '1) halted_next = 1'b1;
          else          pc_next     = pc + PC_WIDTH'(1);
        end
        PcJmp:   pc_next = JmpAddr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) halted <= 1'b0;
    else         halted <= halted_next;
  end

  assign Halted = halted;
`else
  always_comb begin
    pc_next = pc;
    if (pc_step) begin
      case (PcSel)
        PcInc:   pc_next = pc + PC_WIDTH'(1);
        PcJmp:   pc_next = JmpAddr;
        default: ;
      endcase
    end
  end

  assign Halted = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) pc <= '0;
    else         pc <= pc_next;
  end

  // ProgAddr comes straight from the PC flop, so PcSel cannot glitch it.
  assign ProgAddr = pc;

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Instr   <= '0;
      IrValid <= 1'b0;
    end else begin
      if (ir_load) begin
        Instr   <= ProgData;
        IrValid <= 1'b1;
      end else if (pc_step) begin
        IrValid <= 1'b0;
      end
    end
  end

  assign OpCode = opcodes_t'(Instr[INSTR_WIDTH-1 -: 4]);

  // ---------------------------------------------------------------------------
  // Sw8 synchroniser and debouncer (runs every clock, independent of phase)
  // ---------------------------------------------------------------------------
  logic       sw_meta;
  logic       sw_sync;
  logic [7:0] db_count;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= Sw8Raw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      db_count <= '0;
      Sw8      <= 1'b0;
    end else if (sw_sync == Sw8) begin
      db_count <= '0;
    end else if (db_count + 8'd1 == 8'(DEBOUNCE_CYCLES)) begin
      Sw8      <= sw_sync;
      db_count <= '0;
    end else begin
      db_count <= db_count + 8'd1;
    end
  end

endmodule
